// File: rtl/motor_cmd_pkg.sv
// motor_cmd_pkg: command opcodes, channel states and command byte field positions
package motor_cmd_pkg;
  typedef enum logic [1:0] {OP_STOP, OP_FWD, OP_REV, OP_BRAKE} op_e;
  typedef enum logic [2:0] {S_IDLE, S_FWD, S_REV, S_BRAKE, S_DEAD} ch_state_e;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int CH_MSB = 5;
  localparam int CH_LSB = 4;
  localparam int SPD_MSB = 3;
  localparam int SPD_LSB = 0;
endpackage

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge FSM with reversal dead time, duty register and PWM compare (in: clk, reset, cmd_we, op, speed, force_idle, pwm_cnt; out: in1, in2, en)
module motor_channel
  import motor_cmd_pkg::*;
#(
  parameter int PWM_W = 8,
  parameter int DEADTIME_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_we,
  input  op_e              op,
  input  logic [3:0]       speed,
  input  logic             force_idle,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             in1,
  output logic             in2,
  output logic             en
);
  localparam int DW = $clog2(DEADTIME_CYC + 1);
  localparam logic [PWM_W-1:0] FULL = PWM_W'(15) << (PWM_W - 4);
  ch_state_e state, state_nx;
  logic pend_rev, pend_rev_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [PWM_W-1:0] duty, duty_nx;
  logic dir_cmd, dead_done, pwm;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pend_rev <= 1'b0;
      dcnt <= '0;
      duty <= '0;
    end else begin
      state <= state_nx;
      pend_rev <= pend_rev_nx;
      dcnt <= dcnt_nx;
      duty <= duty_nx;
    end
  end
  always_comb begin
    dir_cmd = cmd_we && (op == OP_FWD || op == OP_REV);
    dead_done = dcnt == DW'(DEADTIME_CYC - 1);
    state_nx = state;
    pend_rev_nx = pend_rev;
    dcnt_nx = '0;
    duty_nx = dir_cmd ? PWM_W'(speed) << (PWM_W - 4) : duty;
    if (force_idle || (cmd_we && op == OP_STOP)) state_nx = S_IDLE;
    else if (cmd_we && op == OP_BRAKE) state_nx = S_BRAKE;
    else if (state == S_DEAD) begin
      pend_rev_nx = dir_cmd ? op == OP_REV : pend_rev;
      state_nx = dead_done ? (pend_rev_nx ? S_REV : S_FWD) : S_DEAD;
      dcnt_nx = dead_done ? '0 : dcnt + 1'b1;
    end else if (dir_cmd) begin
      pend_rev_nx = op == OP_REV;
      state_nx = (state == S_FWD && op == OP_REV) || (state == S_REV && op == OP_FWD) ? S_DEAD
               : op == OP_REV ? S_REV : S_FWD;
    end
  end
  assign pwm = duty == FULL || pwm_cnt < duty;
  assign in1 = state == S_FWD;
  assign in2 = state == S_REV;
  assign en = state == S_BRAKE || ((state == S_FWD || state == S_REV) && pwm);
endmodule

// File: rtl/motor_cmd_decoder.sv
// motor_cmd_decoder: byte command decoder for NUM_CH H-bridges with shared PWM counter and optional CMD_WATCHDOG_EN watchdog (in: clk, reset, cmd_valid, cmd_data; out: cmd_ready, in1, in2, en, bad_cmd, timeout)
module motor_cmd_decoder
  import motor_cmd_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int PWM_W = 8,
  parameter int DEADTIME_CYC = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic [NUM_CH-1:0] in1,
  output logic [NUM_CH-1:0] in2,
  output logic [NUM_CH-1:0] en,
  output logic              bad_cmd,
  output logic              timeout
);
  logic acc, wd_fire;
  logic [1:0] ch;
  logic [PWM_W-1:0] pwm_cnt;
  if (NUM_CH < 1 || NUM_CH > 4 || PWM_W < 4 || DEADTIME_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("motor_cmd_decoder: parameter out of range");
  end
  assign cmd_ready = !reset;
  assign acc = cmd_valid && cmd_ready;
  assign ch = cmd_data[CH_MSB:CH_LSB];
  always_ff @(posedge clk) begin
    pwm_cnt <= reset ? '0 : pwm_cnt + 1'b1;
    bad_cmd <= !reset && acc && int'(ch) >= NUM_CH;
  end
`ifdef CMD_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_cnt;
  assign wd_fire = !acc && !timeout && wd_cnt == WW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (reset || acc) begin
      wd_cnt <= '0;
      timeout <= 1'b0;
    end else if (wd_fire) timeout <= 1'b1;
    else if (!timeout) wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motor_channel #(.PWM_W(PWM_W), .DEADTIME_CYC(DEADTIME_CYC)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cmd_we    (acc && ch == 2'(i)),
      .op        (op_e'(cmd_data[OP_MSB:OP_LSB])),
      .speed     (cmd_data[SPD_MSB:SPD_LSB]),
      .force_idle(wd_fire),
      .pwm_cnt   (pwm_cnt),
      .in1       (in1[i]),
      .in2       (in2[i]),
      .en        (en[i])
    );
  end
endmodule

// File: doc/motor_cmd_decoder.md
MOTOR_CMD_DECODER -- requirements
Module: motor_cmd_decoder

Interface
REQ-001 Parameter NUM_CH, default 2: number of H-bridge channels, range 1..4.
REQ-002 Parameter PWM_W, default 8: PWM counter and duty width, minimum 4.
REQ-003 Parameter DEADTIME_CYC, default 4: off cycles inserted on each direction reversal, minimum 1.
REQ-004 Parameter TIMEOUT_CYC, default 50_000_000: command watchdog period in clk cycles.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command byte present.
REQ-008 cmd_data  input  8  command byte: [7:6] op (00 STOP, 01 FWD, 10 REV, 11 BRAKE), [5:4] channel, [3:0] speed.
REQ-009 cmd_ready  output  1  decoder accepts a command this cycle.
REQ-010 in1, in2, en  output  NUM_CH each  per-channel bridge inputs and enable.
REQ-011 bad_cmd  output  1  one-cycle pulse on an accepted command addressed to a channel >= NUM_CH.
REQ-012 timeout  output  1  watchdog expired; held until the next accepted command.

Function
REQ-013 A command SHALL be accepted on any cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 on every cycle except reset cycles.
REQ-014 An accepted command to a valid channel SHALL affect that channel's outputs on the first cycle after acceptance, except where reversal dead time applies.
REQ-015 A command to an invalid channel SHALL change no channel state and SHALL pulse bad_cmd on the cycle after acceptance.
REQ-016 Each channel FSM SHALL have states IDLE, FWD, REV, BRAKE and DEAD.
REQ-017 STOP SHALL move the channel to IDLE; BRAKE SHALL move it to BRAKE. Both take effect from any state, including DEAD.
REQ-018 FWD or REV from IDLE, BRAKE, or the same direction SHALL go directly to that state. The same-direction case updates duty only.
REQ-019 FWD while in REV, or REV while in FWD, SHALL enter DEAD for exactly DEADTIME_CYC cycles, then enter the new direction.
REQ-020 A FWD/REV command arriving during DEAD SHALL replace the pending direction and speed without restarting the dead-time count.
REQ-021 Outputs per state {in1,in2,en}: IDLE 0,0,0; DEAD 0,0,0; BRAKE 0,0,1; FWD 1,0,pwm; REV 0,1,pwm.
REQ-022 The duty register SHALL be loaded on acceptance of FWD/REV; duty = speed << (PWM_W-4).
REQ-023 A shared free-running PWM_W-bit counter SHALL wrap from all-ones to 0.
REQ-024 pwm SHALL be 1 when counter < duty. Speed 0 SHALL give pwm constant 0; speed 15 SHALL give pwm constant 1.
REQ-025 Two commands to different channels on consecutive cycles SHALL both be applied; no command is dropped.

Reset
REQ-026 While reset=1: all channels go to IDLE; in1, in2, en, duty, PWM counter, dead-time counters, watchdog counter, bad_cmd and timeout all go to 0; cmd_ready=0.
REQ-027 Reset asserted mid-dead-time or mid-PWM-period SHALL abort immediately, with no residual pulse after reset is released.

Configuration
REQ-028 With CMD_WATCHDOG_EN defined, a counter SHALL restart on every accepted command, valid channel or not.
REQ-029 With CMD_WATCHDOG_EN defined, reaching TIMEOUT_CYC cycles without an accepted command SHALL force every channel to IDLE and set timeout.
REQ-030 With CMD_WATCHDOG_EN defined, if a command is accepted on the expiry cycle, the command SHALL win and timeout SHALL stay 0.
REQ-031 Without CMD_WATCHDOG_EN, no watchdog logic SHALL exist and timeout SHALL be tied to 0.

Structure
REQ-032 Package motor_cmd_pkg SHALL hold the opcode enum, the channel state enum, and the command field bit positions.
REQ-033 The per-channel FSM, duty register and PWM compare SHALL be sub-module motor_channel, instantiated NUM_CH times by generate.
REQ-034 The PWM counter and the watchdog SHALL live in the top level.

Verification
REQ-035 Reset, then cmd 0x4F (FWD ch0, speed 15) -> next cycle ch0 = {1,0,1} constant; ch1 = {0,0,0}.
REQ-036 FWD speed 8, PWM_W=8 -> en[0] high for exactly 128 of every 256 cycles.
REQ-037 In FWD ch0, cmd 0x8F (REV ch0) -> 4 cycles of {0,0,0}, then {0,1,1}.
REQ-038 During DEAD, cmd 0x00 (STOP ch0) -> ch0 IDLE next cycle; no reverse drive at any later cycle.
REQ-039 NUM_CH=2, cmd 0x7F (FWD ch3) -> bad_cmd pulses 1 cycle; all outputs unchanged.
REQ-040 CMD_WATCHDOG_EN, TIMEOUT_CYC=100, FWD ch1 then idle 100 cycles -> all channels IDLE, timeout=1. Next accepted command -> timeout=0.
